// File: rtl/milano_pkg.sv
// Shared types and constants for the decode stage: ALU operation codes,
// RV32 base opcodes, queue entry layout and the decoded-instruction record.
package milano_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned FIFO_ENTRY_W = 2 * XLEN;

  typedef enum logic [3:0] {
    ALU_NONE   = 4'd0,
    ALU_ADD    = 4'd1,
    ALU_SUB    = 4'd2,
    ALU_XOR    = 4'd3,
    ALU_OR     = 4'd4,
    ALU_AND    = 4'd5,
    ALU_SLL    = 4'd6,
    ALU_SRL    = 4'd7,
    ALU_SRA    = 4'd8,
    ALU_SLT    = 4'd9,
    ALU_SLTU   = 4'd10,
    ALU_MUL    = 4'd11,
    ALU_MULH   = 4'd12,
    ALU_MULHSU = 4'd13,
    ALU_MULHU  = 4'd14
  } alu_opt_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  // Queue entry: instruction PC in the upper half, instruction word below.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;
  } fifo_entry_t;

  // Everything the stage register captures from one decoded instruction.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_wr_en;
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    alu_opt_e              alu_operate;
    logic                  illegal;
  } decode_t;

endpackage

// File: rtl/instr_fifo.sv
// Small circular instruction queue with synchronous flush; DEPTH is a power of two.
module instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));
  assign rdata_o = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy tracking; flush wins over any push or pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Entry storage; cleared on reset so read addresses never float.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: queues fetched words, reads the register file
// from the queue head and stages one decoded instruction for execute.
module id_stage
  import milano_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          RV32M_EN   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [XLEN-1:0]       instr_rdata_i,
  input  logic [XLEN-1:0]       instr_addr_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]       rs1_rdata_i,
  input  logic [XLEN-1:0]       rs2_rdata_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_wr_en_o,
  output logic [XLEN-1:0]       operand_a_o,
  output logic [XLEN-1:0]       operand_b_o,
  output alu_opt_e              alu_operate_o,
  output logic [XLEN-1:0]       pc_o,
  output logic                  illegal_instr_o
);

  fifo_entry_t     wentry;
  fifo_entry_t     head;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  decode_t         dec;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  alu_opt_e        alu;
  logic            legal;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  assign wentry        = '{addr: instr_addr_i, instr: instr_rdata_i};
  assign instr_ready_o = !fifo_full;
  assign push          = instr_valid_i && instr_ready_o && !flush_i;
  assign pop           = !fifo_empty && (!ex_valid_o || ex_ready_i) && !flush_i;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rs1_addr_o = head.instr[19:15];
  assign rs2_addr_o = head.instr[24:20];
  assign opcode     = head.instr[6:0];
  assign funct3     = head.instr[14:12];
  assign funct7     = head.instr[31:25];
  assign imm_i      = {{20{head.instr[31]}}, head.instr[31:20]};
  assign imm_u      = {head.instr[31:12], 12'h000};

  // Decode the queue head; anything unmatched falls through as illegal.
  always_comb begin
    alu   = ALU_NONE;
    op_a  = '0;
    op_b  = '0;
    legal = 1'b0;
    unique case (opcode)
      OPCODE_OP: begin
        op_a = rs1_rdata_i;
        op_b = rs2_rdata_i;
        unique case (funct7)
          7'b0000000: begin
            legal = 1'b1;
            unique case (funct3)
              3'b000:  alu = ALU_ADD;
              3'b001:  alu = ALU_SLL;
              3'b010:  alu = ALU_SLT;
              3'b011:  alu = ALU_SLTU;
              3'b100:  alu = ALU_XOR;
              3'b101:  alu = ALU_SRL;
              3'b110:  alu = ALU_OR;
              default: alu = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000) begin
              alu   = ALU_SUB;
              legal = 1'b1;
            end else if (funct3 == 3'b101) begin
              alu   = ALU_SRA;
              legal = 1'b1;
            end
          end
          7'b0000001: begin
            if (RV32M_EN) begin
              legal = 1'b1;
              unique case (funct3)
                3'b000:  alu = ALU_MUL;
                3'b001:  alu = ALU_MULH;
                3'b010:  alu = ALU_MULHSU;
                3'b011:  alu = ALU_MULHU;
                default: legal = 1'b0;
              endcase
            end
          end
          default: ;
        endcase
      end
      OPCODE_OP_IMM: begin
        op_a  = rs1_rdata_i;
        op_b  = imm_i;
        legal = 1'b1;
        unique case (funct3)
          3'b000: alu = ALU_ADD;
          3'b010: alu = ALU_SLT;
          3'b011: alu = ALU_SLTU;
          3'b100: alu = ALU_XOR;
          3'b110: alu = ALU_OR;
          3'b111: alu = ALU_AND;
          3'b001: begin
            alu   = ALU_SLL;
            legal = (funct7 == 7'b0000000);
          end
          default: begin
            if (funct7 == 7'b0000000)      alu = ALU_SRL;
            else if (funct7 == 7'b0100000) alu = ALU_SRA;
            else                           legal = 1'b0;
          end
        endcase
      end
      OPCODE_LUI: begin
        alu   = ALU_ADD;
        op_b  = imm_u;
        legal = 1'b1;
      end
      OPCODE_AUIPC: begin
        alu   = ALU_ADD;
        op_a  = head.addr;
        op_b  = imm_u;
        legal = 1'b1;
      end
      default: ;
    endcase

    dec.rd_addr     = head.instr[11:7];
    dec.illegal     = !legal;
    dec.rd_wr_en    = legal && (head.instr[11:7] != '0);
    dec.operand_a   = legal ? op_a : '0;
    dec.operand_b   = legal ? op_b : '0;
    dec.alu_operate = legal ? alu : ALU_NONE;
  end

  // Stage register: load on pop, hold under back-pressure, clear on flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o      <= 1'b0;
      rd_addr_o       <= '0;
      rd_wr_en_o      <= 1'b0;
      operand_a_o     <= '0;
      operand_b_o     <= '0;
      alu_operate_o   <= ALU_NONE;
      pc_o            <= '0;
      illegal_instr_o <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (pop) begin
      ex_valid_o      <= 1'b1;
      rd_addr_o       <= dec.rd_addr;
      rd_wr_en_o      <= dec.rd_wr_en;
      operand_a_o     <= dec.operand_a;
      operand_b_o     <= dec.operand_b;
      alu_operate_o   <= dec.alu_operate;
      pc_o            <= head.addr;
      illegal_instr_o <= dec.illegal;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, instruction queue depth; power of two, >= 2.
REQ-002 Parameter RV32M_EN, default 0, 1 = decode RV32M multiply ops, 0 = report them illegal.
REQ-003 clk_i  input  1  sole clock, all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 instr_valid_i  input  1  fetch presents instruction.
REQ-006 instr_ready_o  output  1  queue can accept.
REQ-007 instr_rdata_i  input  32  instruction word.
REQ-008 instr_addr_i  input  32  instruction PC.
REQ-009 flush_i  input  1  discard all queued and staged instructions.
REQ-010 rs1_addr_o, rs2_addr_o  output  5 each  register file read addresses, from queue head.
REQ-011 rs1_rdata_i, rs2_rdata_i  input  32 each  register file read data, same cycle as addresses.
REQ-012 ex_valid_o  output  1  decoded instruction staged for EX.
REQ-013 ex_ready_i  input  1  EX accepts staged instruction.
REQ-014 rd_addr_o  output  5; rd_wr_en_o  output  1; operand_a_o, operand_b_o  output  32 each; alu_operate_o  output  alu_opt_e; pc_o  output  32; illegal_instr_o  output  1.

Function
REQ-015 Queue push when instr_valid_i && instr_ready_o; instr_ready_o = (count < FIFO_DEPTH), independent of instr_valid_i.
REQ-016 Queue pop when queue non-empty and stage register free or being drained (!ex_valid_o || ex_ready_i).
REQ-017 Simultaneous push and pop: count unchanged; push to full queue never occurs; pointers wrap modulo FIFO_DEPTH.
REQ-018 Stage register loads decode of queue head on pop; holds outputs stable while ex_valid_o && !ex_ready_i.
REQ-019 Latency: instruction pushed at edge E into empty queue with free stage appears on ex_valid_o after edge E+1; throughput one per cycle.
REQ-020 ex_valid_o clears on edge where ex_ready_i is high and no pop occurs.
REQ-021 OP: a = rs1_rdata_i, b = rs2_rdata_i, rd_wr_en = 1; funct7/funct3 map ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU.
REQ-022 OP with funct7 = 0000001 and RV32M_EN = 1: funct3 000/001/010/011 -> ALU_MUL/MULH/MULHSU/MULHU; other funct3 illegal.
REQ-023 OP_IMM: a = rs1_rdata_i, b = sign-extended instr[31:20]; ADDI, XORI, ORI, ANDI, SLTI, SLTIU; SLLI/SRLI need funct7 = 0, SRAI needs 0100000, else illegal.
REQ-024 LUI: a = 0, b = {instr[31:12], 12'h0}, ALU_ADD; AUIPC: a = instruction PC, b = same immediate, ALU_ADD.
REQ-025 Any other opcode or unmatched funct: illegal_instr_o = 1, rd_wr_en_o = 0, alu_operate_o = ALU_NONE, operands 0, still staged with ex_valid_o = 1.
REQ-026 rd_wr_en_o forced 0 when rd = x0.
REQ-027 pc_o carries instruction PC of staged entry.
REQ-028 flush_i: on that edge count, pointers, ex_valid_o clear; push and pop in that cycle discarded; flush has priority over all events.

Reset
REQ-029 On rst_i: queue empty, pointers 0, ex_valid_o 0, rd_addr_o 0, rd_wr_en_o 0, operands 0, pc_o 0, alu_operate_o ALU_NONE, illegal_instr_o 0; instr_ready_o 1 once rst_i deasserts.
REQ-030 Reset mid-operation discards all queued and staged instructions immediately (asynchronous), no output glitch to ex_valid_o = 1.

Structure
REQ-031 milano_pkg gains ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, OPCODE_LUI, OPCODE_AUIPC.
REQ-032 Queue is one sub-module, instr_fifo, parametrised on depth and entry width (64: instruction + PC).

Verification
REQ-033 ADDI x1,x0,-1 (0xFFF00093), rs1_rdata 0 -> next cycle ex_valid 1, ALU_ADD, a 0, b 0xFFFFFFFF, rd 1, wr_en 1.
REQ-034 LUI x5,0x12345 (0x123452B7) -> a 0, b 0x12345000, ALU_ADD, rd 5; AUIPC at PC 0x100 with same imm -> a 0x100.
REQ-035 MUL x3,x1,x2 (0x022081B3): RV32M_EN=0 -> illegal 1, wr_en 0; RV32M_EN=1 -> ALU_MUL, illegal 0.
REQ-036 FIFO_DEPTH 2, ex_ready_i 0, push 4 back-to-back -> 3 accepted (2 queued + 1 staged), instr_ready_o 0; release ex_ready_i -> drained in order, one per cycle.
REQ-037 flush_i with 2 queued, 1 staged, concurrent push -> next cycle ex_valid 0, queue empty, pushed word absent.
REQ-038 rst_i asserted mid-stream -> all outputs at REQ-029 values before next clock edge.
